// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: captures a fixed-length payload after sync and re-sends it as RF pulses.
// Optional feature macro: FRAME_PARITY_EN (adds an even-parity bit after the payload).
module rx_frame_buffer #(
   parameter int PAYLOAD_BITS = 32,
   parameter int BIT_CYCLES   = 10000,
   parameter int PULSE_CYCLES = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    rfin,
   input  logic                    sh_en,
   input  logic                    fsm_rst,
   input  logic                    RX,
   input  logic                    tx_rdy,
   output logic [PAYLOAD_BITS-1:0] frame_data,
   output logic                    frame_valid,
   output logic                    tx_pulse,
   output logic                    tx_busy,
   output logic                    tx_done,
   output logic                    overrun,
   output logic                    parity_err
);

   localparam int SLOT_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam int CNT_W  = $clog2(PAYLOAD_BITS + 2);
`ifdef FRAME_PARITY_EN
   localparam int TX_BITS = PAYLOAD_BITS + 1;
   localparam logic [CNT_W-1:0] PARITY_SLOT = CNT_W'(PAYLOAD_BITS);
`else
   localparam int TX_BITS = PAYLOAD_BITS;
   localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(PAYLOAD_BITS - 1);
`endif
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(BIT_CYCLES - 1);
   localparam logic [SLOT_W-1:0] PULSE_END = SLOT_W'(PULSE_CYCLES);
   localparam logic [CNT_W-1:0]  LAST_TX   = CNT_W'(TX_BITS - 1);

   typedef enum logic [1:0] {IDLE, CAPTURE, FULL, TX} state_t;
   state_t state, next_state;

   logic                rfin_m;
   logic                rfin_s;
   logic                slot_latch;
   logic                sample_bit;
   logic [CNT_W-1:0]    count;
   logic [CNT_W-1:0]    bit_idx;
   logic [SLOT_W-1:0]   slot;
   logic [TX_BITS-1:0]  tx_sr;
   logic                slot_end;
   logic                load_first;
   logic                shift_in;
   logic                clear_frame;
   logic                set_overrun;
   logic                start_tx;
   logic                tx_last;
   logic                tx_abort;
`ifdef FRAME_PARITY_EN
   logic                parity_bit;
   logic                parity_ok;
   logic                parity_fail;
`endif

   // rfin is asynchronous; a pulse anywhere in the slot is remembered until the strobe
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rfin_m     <= 1'b0;
         rfin_s     <= 1'b0;
         slot_latch <= 1'b0;
      end else begin
         rfin_m <= rfin;
         rfin_s <= rfin_m;
         if (sh_en || clear_frame)
            slot_latch <= 1'b0;
         else if (rfin_s)
            slot_latch <= 1'b1;
      end
   end

   assign sample_bit = slot_latch | rfin_s;
   assign slot_end   = (slot == SLOT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state  = state;
      load_first  = 1'b0;
      shift_in    = 1'b0;
      clear_frame = 1'b0;
      set_overrun = 1'b0;
      start_tx    = 1'b0;
      tx_last     = 1'b0;
      tx_abort    = 1'b0;
`ifdef FRAME_PARITY_EN
      parity_ok   = 1'b0;
      parity_fail = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (fsm_rst) begin
               clear_frame = 1'b1;
            end else if (sh_en) begin
               load_first = 1'b1;
               next_state = CAPTURE;
            end
         end
         CAPTURE: begin
            if (fsm_rst) begin
               clear_frame = 1'b1;
               next_state  = IDLE;
            end else if (sh_en) begin
`ifdef FRAME_PARITY_EN
               if (count == PARITY_SLOT) begin
                  if (sample_bit == ^frame_data) begin
                     parity_ok  = 1'b1;
                     next_state = FULL;
                  end else begin
                     parity_fail = 1'b1;
                     clear_frame = 1'b1;
                     next_state  = IDLE;
                  end
               end else begin
                  shift_in = 1'b1;
               end
`else
               shift_in = 1'b1;
               if (count == LAST_DATA)
                  next_state = FULL;
`endif
            end
         end
         FULL: begin
            set_overrun = sh_en;
            if (!RX && tx_rdy) begin
               start_tx   = 1'b1;
               next_state = TX;
            end
         end
         TX: begin
            // returning to receive mode abandons the frame without a done strobe
            if (RX) begin
               tx_abort    = 1'b1;
               clear_frame = 1'b1;
               next_state  = IDLE;
            end else if (slot_end && bit_idx == LAST_TX) begin
               tx_last    = 1'b1;
               next_state = IDLE;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         frame_data <= '0;
         count      <= '0;
      end else if (clear_frame) begin
         frame_data <= '0;
         count      <= '0;
      end else if (load_first) begin
         frame_data <= {{(PAYLOAD_BITS-1){1'b0}}, sample_bit};
         count      <= CNT_W'(1);
      end else if (shift_in) begin
         frame_data <= {frame_data[PAYLOAD_BITS-2:0], sample_bit};
         count      <= count + CNT_W'(1);
      end else if (tx_last) begin
         count <= '0;
      end
   end

   // a separate shift copy keeps frame_data frozen while the slots go out MSB-first
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot    <= '0;
         bit_idx <= '0;
         tx_sr   <= '0;
      end else if (start_tx) begin
         slot    <= '0;
         bit_idx <= '0;
`ifdef FRAME_PARITY_EN
         tx_sr   <= {frame_data, parity_bit};
`else
         tx_sr   <= frame_data;
`endif
      end else if (state == TX) begin
         if (slot_end) begin
            slot    <= '0;
            bit_idx <= bit_idx + CNT_W'(1);
            tx_sr   <= {tx_sr[TX_BITS-2:0], 1'b0};
         end else begin
            slot <= slot + SLOT_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overrun <= 1'b0;
         tx_done <= 1'b0;
      end else begin
         tx_done <= tx_last;
         if (tx_last || tx_abort)
            overrun <= 1'b0;
         else if (set_overrun)
            overrun <= 1'b1;
      end
   end

`ifdef FRAME_PARITY_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         parity_bit <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         parity_err <= parity_fail;
         if (parity_ok)
            parity_bit <= sample_bit;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

   assign frame_valid = (state == FULL) || (state == TX);
   assign tx_busy     = (state == TX);
   assign tx_pulse    = tx_busy && !RX && tx_sr[TX_BITS-1] && (slot < PULSE_END);

endmodule

// File: tb/tb_rx_frame_buffer.sv
`timescale 1ns/1ps
// tb_rx_frame_buffer: randomized frames into rx_frame_buffer; a queue scoreboard and a
// monitor compare captured words and the serialized pulse train against a slot model.
module tb_rx_frame_buffer;

   localparam int PB = 32;
   localparam int BC = 20;
   localparam int PC = 2;
`ifdef FRAME_PARITY_EN
   localparam int TXB = PB + 1;
`else
   localparam int TXB = PB;
`endif

   logic          clk;
   logic          rst;
   logic          rfin;
   logic          sh_en;
   logic          fsm_rst;
   logic          RX;
   logic          tx_rdy;
   logic [PB-1:0] frame_data;
   logic          frame_valid;
   logic          tx_pulse;
   logic          tx_busy;
   logic          tx_done;
   logic          overrun;
   logic          parity_err;

   int checks;
   int failures;

   typedef struct packed {
      logic [PB-1:0] word;
      logic          abort;
   } tx_exp_t;

   logic [PB-1:0] frame_q[$];
   tx_exp_t       tx_q[$];

   rx_frame_buffer #(
      .PAYLOAD_BITS (PB),
      .BIT_CYCLES   (BC),
      .PULSE_CYCLES (PC)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .rfin        (rfin),
      .sh_en       (sh_en),
      .fsm_rst     (fsm_rst),
      .RX          (RX),
      .tx_rdy      (tx_rdy),
      .frame_data  (frame_data),
      .frame_valid (frame_valid),
      .tx_pulse    (tx_pulse),
      .tx_busy     (tx_busy),
      .tx_done     (tx_done),
      .overrun     (overrun),
      .parity_err  (parity_err)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;

   task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // one payload slot: optional 1-cycle rfin pulse, settle, then the end-of-slot strobe
   task automatic sendSlot(input logic b);
      repeat ($urandom_range(0, 2)) tick();
      if (b) begin
         rfin = 1'b1;
         tick();
         rfin = 1'b0;
      end
      repeat (3 + $urandom_range(0, 2)) tick();
      sh_en = 1'b1;
      tick();
      sh_en = 1'b0;
   endtask

   task automatic applyStimulus(input logic [PB-1:0] word, input logic extra, input logic bad_par);
      if (!bad_par) frame_q.push_back(word);
      for (int i = PB - 1; i >= 0; i--) sendSlot(word[i]);
`ifdef FRAME_PARITY_EN
      sendSlot((^word) ^ bad_par);
      if (bad_par) checkOutput("parity_err_pulse", parity_err, 1);
`else
      checkOutput("parity_err_tied", parity_err, 0);
`endif
      checkOutput("valid_after_last_strobe", frame_valid, !bad_par);
      if (extra) begin
         sh_en = 1'b1;
         tick();
         sh_en = 1'b0;
      end
      checkOutput("overrun_state", overrun, extra);
   endtask

   task automatic startTx(input logic [PB-1:0] word, input logic abort);
      tx_exp_t e;
      RX = 1'b1;
      tx_rdy = 1'b1;
      repeat (2) tick();
      checkOutput("tx_hold_rx", tx_busy, 0);
      RX = 1'b0;
      tx_rdy = 1'b0;
      repeat (2) tick();
      checkOutput("tx_hold_rdy", tx_busy, 0);
      checkOutput("valid_while_held", frame_valid, 1);
      e.word  = word;
      e.abort = abort;
      tx_q.push_back(e);
      tx_rdy = 1'b1;
      tick();
      tx_rdy = 1'($urandom_range(0, 1));
      checkOutput("tx_start", tx_busy, 1);
   endtask

   task automatic waitTxDone();
      int n;
      n = 1;
      while (!tx_done && n < TXB * BC + 50) begin
         tick();
         n++;
      end
      checkOutput("tx_done_latency", n, TXB * BC + 1);
      checkOutput("tx_overrun_cleared", overrun, 0);
      checkOutput("tx_valid_cleared", frame_valid, 0);
      RX = 1'b1;
      tx_rdy = 1'b0;
      tick();
      checkOutput("tx_done_one_cycle", tx_done, 0);
   endtask

   task automatic rxAbort(input logic [PB-1:0] word);
      startTx(word, 1'b1);
      repeat ($urandom_range(30, 500)) tick();
      RX = 1'b1;
      tx_rdy = 1'b0;
      repeat (2) tick();
      checkOutput("abort_busy", tx_busy, 0);
      checkOutput("abort_valid", frame_valid, 0);
      checkOutput("abort_done", tx_done, 0);
   endtask

   // monitor: pops expectations whenever the DUT presents a frame or a transmission
   initial begin : monitor
      logic    prev_valid;
      logic    in_tx;
      logic    eb;
      logic    exp_p;
      tx_exp_t cur;
      int      c;
      int      perr;
      int      idx;
      prev_valid = 1'b0;
      in_tx = 1'b0;
      cur = '0;
      c = 0;
      perr = 0;
      forever begin
         @(negedge clk);
         if (frame_valid && !prev_valid && !tx_busy) begin
            checkOutput("frame_expected", frame_q.size() > 0, 1);
            if (frame_q.size() > 0) checkOutput("frame_data", frame_data, frame_q.pop_front());
         end
         if (!in_tx && tx_busy) begin
            checkOutput("tx_expected", tx_q.size() > 0, 1);
            if (tx_q.size() > 0) cur = tx_q.pop_front();
            in_tx = 1'b1;
            c = 0;
            perr = 0;
         end
         if (in_tx && tx_busy) begin
            idx = c / BC;
            eb = (idx < PB) ? cur.word[PB - 1 - idx] : ^cur.word;
            exp_p = eb && ((c % BC) < PC) && !RX;
            if (tx_pulse !== exp_p) perr++;
            c++;
         end else if (in_tx) begin
            in_tx = 1'b0;
            checkOutput("tx_pulse_train", perr, 0);
            if (cur.abort) begin
               checkOutput("abort_no_done", tx_done, 0);
               checkOutput("abort_pulse_low", tx_pulse, 0);
            end else begin
               checkOutput("tx_length", c, TXB * BC);
               checkOutput("tx_done_strobe", tx_done, 1);
               checkOutput("tx_end_valid", frame_valid, 0);
            end
         end
         prev_valid = frame_valid;
      end
   end

   initial begin : watchdog
      #6000000;
      $display("[TB] FAIL watchdog: simulation exceeded its cycle budget");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin : driver
      logic [PB-1:0] w;
      checks = 0;
      failures = 0;
      rst = 1'b1;
      rfin = 1'b0;
      sh_en = 1'b0;
      fsm_rst = 1'b0;
      RX = 1'b1;
      tx_rdy = 1'b0;
      repeat (3) tick();
      checkOutput("reset_frame_data", frame_data, 0);
      checkOutput("reset_frame_valid", frame_valid, 0);
      checkOutput("reset_tx_pulse", tx_pulse, 0);
      checkOutput("reset_tx_busy", tx_busy, 0);
      checkOutput("reset_tx_done", tx_done, 0);
      checkOutput("reset_overrun", overrun, 0);
      checkOutput("reset_parity_err", parity_err, 0);
      rst = 1'b0;
      tick();

      $display("[TB] frame DD595B5C, overrun and full transmit");
      applyStimulus(32'hDD595B5C, 1'b0, 1'b0);
      repeat (3) sendSlot(1'($urandom_range(0, 1)));
      checkOutput("overrun_sticky", overrun, 1);
      checkOutput("overrun_frame_frozen", frame_data, 32'hDD595B5C);
      checkOutput("overrun_still_valid", frame_valid, 1);
      startTx(32'hDD595B5C, 1'b0);
      waitTxDone();

      $display("[TB] fsm_rst mid-frame, then 0000FFFF with reset during transmit");
      for (int i = 0; i < 10; i++) sendSlot(1'($urandom_range(0, 1)));
      rfin = 1'b1;
      tick();
      rfin = 1'b0;
      repeat (3) tick();
      sh_en = 1'b1;
      fsm_rst = 1'b1;
      tick();
      sh_en = 1'b0;
      fsm_rst = 1'b0;
      checkOutput("fsm_rst_valid", frame_valid, 0);
      checkOutput("fsm_rst_cleared", frame_data, 0);
      applyStimulus(32'h0000FFFF, 1'b0, 1'b0);
      startTx(32'h0000FFFF, 1'b1);
      repeat (5 * BC + 3) tick();
      rst = 1'b1;
      #1;
      checkOutput("rst_tx_busy", tx_busy, 0);
      checkOutput("rst_tx_pulse", tx_pulse, 0);
      checkOutput("rst_frame_valid", frame_valid, 0);
      checkOutput("rst_frame_data", frame_data, 0);
      checkOutput("rst_tx_done", tx_done, 0);
      tick();
      rst = 1'b0;
      RX = 1'b1;
      tx_rdy = 1'b0;
      tick();

      $display("[TB] frame A0000001 with strobe on FULL entry, full transmit");
      applyStimulus(32'hA0000001, 1'b1, 1'b0);
      startTx(32'hA0000001, 1'b0);
      waitTxDone();

      $display("[TB] random frames");
      for (int f = 0; f < 4; f++) begin
         w = $urandom;
         applyStimulus(w, 1'b0, 1'b0);
         if (f == 1 || $urandom_range(0, 3) == 0) begin
            rxAbort(w);
         end else begin
            startTx(w, 1'b0);
            waitTxDone();
         end
      end

`ifdef FRAME_PARITY_EN
      $display("[TB] parity check frames");
      applyStimulus(32'h00000001, 1'b0, 1'b1);
      tick();
      checkOutput("parity_err_one_cycle", parity_err, 0);
      applyStimulus(32'h00000001, 1'b0, 1'b0);
      startTx(32'h00000001, 1'b0);
      waitTxDone();
`endif

      repeat (4) tick();
      checkOutput("frame_queue_drained", frame_q.size(), 0);
      checkOutput("tx_queue_drained", tx_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
